// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file -- 16 x 16-bit register file for a small 16-bit CPU core.
//
// Register roles: R0 = PC, R1 = SP, R2 = SR (status), R3 = CG2 (constant gen).
//
// Optional feature macro: CONST_GEN_EN
//   defined   : SA=3 and SA=2 source reads are overridden by the constant
//               generator (selected by As); writes to R3 are discarded.
//   undefined : R3 is an ordinary register, SA=2 always reads SR, As unused.
//
// Ports:
//   clk         in   1     clock, all state changes on the rising edge
//   rst         in   1     asynchronous active-high reset, clears R0-R15
//   SA          in   4     source register select (drives A)
//   DA          in   4     destination register select (drives B, write target)
//   As          in   2     source addressing mode (constant generator only)
//   RW          in   1     write F_in into R[DA]
//   BW          in   1     1 = byte write (upper byte zeroed), 0 = word write
//   F_in        in   SIZE  writeback data from the function unit
//   CVNZ_in     in   4     function unit flags [3]=C [2]=V [1]=N [0]=Z
//   SR_upd      in   1     load flags from CVNZ_in into SR
//   PC_inc      in   1     advance PC by 2
//   A           out  SIZE  source operand (combinational read of R[SA])
//   B           out  SIZE  destination operand (combinational read of R[DA])
//   reg_SR_out  out  16    current SR (R2), straight from the register
//   reg_PC_out  out  16    current PC (R0), straight from the register
//
// Only SIZE = 16 is supported.
// -----------------------------------------------------------------------------
module reg_file #(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      SA,
  input  logic [3:0]      DA,
  input  logic [1:0]      As,
  input  logic            RW,
  input  logic            BW,
  input  logic [SIZE-1:0] F_in,
  input  logic [3:0]      CVNZ_in,
  input  logic            SR_upd,
  input  logic            PC_inc,
  output logic [SIZE-1:0] A,
  output logic [SIZE-1:0] B,
  output logic [15:0]     reg_SR_out,
  output logic [15:0]     reg_PC_out
);

  localparam int NREG = 16;

  // Register array and its next state
  logic [NREG-1:0][SIZE-1:0] regs_q;
  logic [NREG-1:0][SIZE-1:0] regs_d;

  // Write path helpers
  logic            wr_en_s;
  logic [SIZE-1:0] wr_data_s;
  logic [SIZE-1:0] wr_val_s;
  logic [SIZE-1:0] sr_base_s;
  logic [SIZE-1:0] sr_next_s;

  // Flag fields of CVNZ_in
  logic flag_c_s;
  logic flag_v_s;
  logic flag_n_s;
  logic flag_z_s;

  assign flag_c_s = CVNZ_in[3];
  assign flag_v_s = CVNZ_in[2];
  assign flag_n_s = CVNZ_in[1];
  assign flag_z_s = CVNZ_in[0];

  // Write enable qualification; R3 is read-only when it is the constant generator
  always_comb begin
    wr_en_s = RW;
`ifdef CONST_GEN_EN
    if (DA == 4'd3) begin
      wr_en_s = 1'b0;
    end else begin
      wr_en_s = RW;
    end
`endif
  end

  // Byte/word formatting and per-register write masking
  always_comb begin
    wr_data_s = '0;
    wr_val_s  = '0;
    if (BW) begin
      wr_data_s = {{(SIZE-8){1'b0}}, F_in[7:0]};
    end else begin
      wr_data_s = F_in;
    end
    case (DA)
      // PC and SP are always word aligned
      4'd0, 4'd1: wr_val_s = {wr_data_s[SIZE-1:1], 1'b0};
      default:    wr_val_s = wr_data_s;
    endcase
  end

  // Next-state: write beats PC increment, then SR flag merge on top of the write
  always_comb begin
    regs_d    = regs_q;
    sr_base_s = '0;
    sr_next_s = '0;
    for (int i = 0; i < NREG; i++) begin
      if (wr_en_s && (DA == 4'(i))) begin
        regs_d[i] = wr_val_s;
      end else if ((i == 0) && PC_inc) begin
        regs_d[i] = regs_q[0] + 16'd2;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
    // SR: flags land in bits 0/1/2/8; bits 15:9 are hard zero
    sr_base_s = regs_d[2];
    if (SR_upd) begin
      sr_next_s = {7'b000_0000, flag_v_s, sr_base_s[7:3], flag_n_s, flag_z_s, flag_c_s};
    end else begin
      sr_next_s = {7'b000_0000, sr_base_s[8:0]};
    end
    regs_d[2] = sr_next_s;
  end

  // State register; reset also kills any write pending on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Source operand read, with optional constant generator override
`ifdef CONST_GEN_EN
  always_comb begin
    A = regs_q[SA];
    case (SA)
      4'd3: begin
        case (As)
          2'b00:   A = 16'h0000;
          2'b01:   A = 16'h0001;
          2'b10:   A = 16'h0002;
          2'b11:   A = 16'hFFFF;
          default: A = 16'h0000;
        endcase
      end
      4'd2: begin
        case (As)
          2'b00:   A = regs_q[2];
          2'b01:   A = 16'h0000;
          2'b10:   A = 16'h0004;
          2'b11:   A = 16'h0008;
          default: A = regs_q[2];
        endcase
      end
      default: A = regs_q[SA];
    endcase
  end
`else
  // As only matters for the constant generator
  logic unused_as_s;
  assign unused_as_s = ^As;

  // Plain source read
  always_comb begin
    A = regs_q[SA];
  end
`endif

  // Destination operand read; never touched by the constant generator
  always_comb begin
    B = regs_q[DA];
  end

  assign reg_SR_out = regs_q[2];
  assign reg_PC_out = regs_q[0];

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter: SIZE, default 16, datapath width in bits; only 16 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 SA  input  4  source register select; drives A.
REQ-005 DA  input  4  destination register select; drives B and selects the write target.
REQ-006 As  input  2  source addressing mode; used only for constant generation.
REQ-007 RW  input  1  write enable for F_in into R[DA].
REQ-008 BW  input  1  byte operation: 1 = byte, 0 = word.
REQ-009 F_in  input  SIZE  writeback data from the function unit result.
REQ-010 CVNZ_in  input  4  flags from the function unit: [3]=C, [2]=V, [1]=N, [0]=Z.
REQ-011 SR_upd  input  1  load flags from CVNZ_in into SR.
REQ-012 PC_inc  input  1  advance PC by 2.
REQ-013 A  output  SIZE  source operand to the function unit.
REQ-014 B  output  SIZE  destination operand to the function unit.
REQ-015 reg_SR_out  output  16  current R2 (SR).
REQ-016 reg_PC_out  output  16  current R0 (PC).

Function
REQ-017 Storage SHALL be 16 registers, R0-R15; R0=PC, R1=SP, R2=SR, R3=CG2.
REQ-018 A SHALL be R[SA] and B SHALL be R[DA], both combinational with no write bypass; a written value SHALL become visible the cycle after the write edge.
REQ-019 When RW=1, R[DA] SHALL load F_in if BW=0, or {8'h00, F_in[7:0]} if BW=1.
REQ-020 Writes to R0 and R1 SHALL force bit 0 to 0.
REQ-021 SR bits 15:9 SHALL always read 0, and writes to those bits SHALL be discarded.
REQ-022 When PC_inc=1, R0 SHALL load R0+2 modulo 2^16 (0xFFFE -> 0x0000).
REQ-023 If RW=1 and DA=0 while PC_inc=1, the RW write SHALL win and the increment SHALL be dropped.
REQ-024 When SR_upd=1, the SR flag bits SHALL load as follows: bit0=C, bit1=Z, bit2=N, bit8=V; all other SR bits SHALL be unchanged.
REQ-025 If RW=1 and DA=2 while SR_upd=1, bits 0/1/2/8 SHALL take the flag values, and the remaining bits 7:3 SHALL take F_in (or its byte-masked form when BW=1).
REQ-026 Writes to R1 and R4-R15 SHALL have no side effects on any other register.
REQ-027 reg_SR_out and reg_PC_out SHALL reflect the registered values with no combinational path from inputs.

Reset
REQ-028 rst=1 SHALL asynchronously clear R0-R15 to 0x0000, so A, B, reg_SR_out and reg_PC_out read 0x0000 (except constant-generator reads, see REQ-031).
REQ-029 While rst=1, RW, PC_inc and SR_upd SHALL be ignored.
REQ-030 The first state update SHALL occur on the first rising clk edge after rst deasserts; reset asserted mid-operation SHALL discard any write pending on that edge.

Configuration
REQ-031 With macro CONST_GEN_EN defined, the constant generator SHALL override the source read:
- SA=3: A = 0x0000, 0x0001, 0x0002, 0xFFFF for As = 00, 01, 10, 11.
- SA=2: A = SR for As=00; 0x0000 for As=01; 0x0004 for As=10; 0x0008 for As=11.
- Writes with DA=3 SHALL be discarded.
REQ-032 Without CONST_GEN_EN:
- SA=3 SHALL read the stored R3, and R3 SHALL be writable like R4-R15.
- SA=2 SHALL always read SR.
- As SHALL be ignored.
REQ-033 B SHALL never be affected by the constant generator in either configuration.

Verification
REQ-034 Reset: drive rst=1 asynchronously mid-cycle with RW=1 -> all outputs read 0x0000 immediately, and no write occurs.
REQ-035 Write/read: RW=1, DA=5, F_in=0xA5C3, BW=0 -> next cycle SA=5 gives A=0xA5C3; repeat with BW=1 -> A=0x00C3.
REQ-036 PC:
- R0=0xFFFE, PC_inc=1 -> 0x0000.
- PC_inc=1 with RW=1, DA=0, F_in=0x1235 -> reg_PC_out=0x1234.
REQ-037 Flags: SR_upd=1, CVNZ_in=4'b1010 -> reg_SR_out=0x0005; then SR_upd=1 with RW=1, DA=2, F_in=0xFFFF, CVNZ_in=0 -> reg_SR_out=0x00F8.
REQ-038 Constant generator (CONST_GEN_EN defined): SA=3, As=11 -> A=0xFFFF; SA=2, As=10 -> A=0x0004; RW=1, DA=3 -> R3 is unchanged.
REQ-039 No constant generator (CONST_GEN_EN undefined): RW=1, DA=3, F_in=0x0042, then SA=3, As=11 -> A=0x0042.
